// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with increment, relative branch,
// absolute jump, and call/return through an optional return-address stack.
//
// Parameters:
//   ADDR_W    - PC width; instruction memory holds 2^ADDR_W words
//   RESET_VEC - value loaded into pc_out on reset
//   RAS_DEPTH - return-address stack entries (power of two, >= 2)
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   stall      - hold PC and stack this cycle
//   branch_en  - PC-relative branch, pc_out + branch_off (signed)
//   branch_off - two's-complement branch offset
//   jump_en    - absolute jump to target
//   call_en    - push pc_out + 1, jump to target
//   ret_en     - pop the stack into the PC
//   target     - absolute destination for jump and call
//   pc_out     - registered fetch address
//   pc_next    - combinational value pc_out takes at the next edge
//   ras_empty  - stack holds no entries
//   ras_full   - stack holds RAS_DEPTH entries
//   ras_err    - sticky push-while-full / pop-while-empty flag
//
// Build option: define PC_RAS_EN to build the return-address stack.
// Without it, call_en acts as jump_en, ret_en is ignored, and the flags
// are tied off (ras_empty = 1, ras_full = 0, ras_err = 0).

module pc_sequencer #(
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned RESET_VEC = 0,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_en,
   input  logic [ADDR_W-1:0] branch_off,
   input  logic              jump_en,
   input  logic              call_en,
   input  logic              ret_en,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_next,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_err
);

   localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_br;
   logic [ADDR_W-1:0] pc_nx;

   // Both sums wrap modulo 2^ADDR_W; a signed offset added as unsigned
   // gives the same low ADDR_W bits, so backward branches need no sign logic.
   assign pc_inc = pc_q + ADDR_W'(1);
   assign pc_br  = pc_q + branch_off;

`ifdef PC_RAS_EN

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   // sp addresses the next free slot; the top entry sits at sp - 1.
   // When full, sp wraps onto the oldest entry so a push overwrites it.
   logic [PTR_W-1:0]  sp;
   logic [CNT_W-1:0]  cnt;
   logic              err_q;
   logic [ADDR_W-1:0] ras_top;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic              err_set;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CNT_MAX);
   assign ras_top = ras_mem[sp - PTR_W'(1)];

   always_comb begin
      pc_nx   = pc_inc;
      push    = 1'b0;
      pop     = 1'b0;
      err_set = 1'b0;
      if (rst) begin
         pc_nx = RST_PC;
      end else if (stall) begin
         pc_nx = pc_q;
      end else if (ret_en) begin
         if (!empty) begin
            pop   = 1'b1;
            pc_nx = ras_top;
         end else begin
            err_set = 1'b1;
         end
      end else if (call_en) begin
         push    = 1'b1;
         pc_nx   = target;
         err_set = full;
      end else if (jump_en) begin
         pc_nx = target;
      end else if (branch_en) begin
         pc_nx = pc_br;
      end
   end

   // Stack contents need no reset; count and pointer define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         ras_mem[sp] <= pc_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RST_PC;
         sp    <= '0;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q <= pc_nx;
         if (push) begin
            sp <= sp + PTR_W'(1);
            if (!full) begin
               cnt <= cnt + CNT_W'(1);
            end
         end else if (pop) begin
            sp  <= sp - PTR_W'(1);
            cnt <= cnt - CNT_W'(1);
         end
         if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   assign ras_empty = empty;
   assign ras_full  = full;
   assign ras_err   = err_q;

`else

   // Without a stack, a call is just a jump and a return is not a request.
   logic unused_ret;
   assign unused_ret = ret_en;

   always_comb begin
      pc_nx = pc_inc;
      if (rst) begin
         pc_nx = RST_PC;
      end else if (stall) begin
         pc_nx = pc_q;
      end else if (call_en || jump_en) begin
         pc_nx = target;
      end else if (branch_en) begin
         pc_nx = pc_br;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RST_PC;
      end else begin
         pc_q <= pc_nx;
      end
   end

   assign ras_empty = 1'b1;
   assign ras_full  = 1'b0;
   assign ras_err   = 1'b0;

`endif

   assign pc_out  = pc_q;
   assign pc_next = pc_nx;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus for pc_sequencer, checked
// against a queue-based model of the PC and return-address stack.

module tb_pc_sequencer;

   localparam int AW    = 6;
   localparam int RV    = 5;
   localparam int DEPTH = 4;
   localparam int MASK  = (1 << AW) - 1;

`ifdef PC_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stall = 1'b0;
   logic          branch_en = 1'b0;
   logic [AW-1:0] branch_off = '0;
   logic          jump_en = 1'b0;
   logic          call_en = 1'b0;
   logic          ret_en = 1'b0;
   logic [AW-1:0] target = '0;
   logic [AW-1:0] pc_out;
   logic [AW-1:0] pc_next;
   logic          ras_empty;
   logic          ras_full;
   logic          ras_err;

   pc_sequencer #(
      .ADDR_W   (AW),
      .RESET_VEC(RV),
      .RAS_DEPTH(DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .branch_en (branch_en),
      .branch_off(branch_off),
      .jump_en   (jump_en),
      .call_en   (call_en),
      .ret_en    (ret_en),
      .target    (target),
      .pc_out    (pc_out),
      .pc_next   (pc_next),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .ras_err   (ras_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int fails = 0;

   int m_pc = 0;
   int m_q[$];
   bit m_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Behavioural reference: PC as an integer, stack as a bounded queue
   // whose front is the oldest return address.
   task automatic model(input bit r, input bit s, input bit br,
                        input int off, input bit j, input bit c,
                        input bit rt, input int tgt);
      if (r) begin
         m_pc = RV;
         m_q.delete();
         m_err = 1'b0;
      end else if (s) begin
         m_pc = m_pc;
      end else if (RAS_ON && rt) begin
         if (m_q.size() > 0) begin
            m_pc = m_q.pop_back();
         end else begin
            m_pc = (m_pc + 1) & MASK;
            m_err = 1'b1;
         end
      end else if (RAS_ON && c) begin
         m_q.push_back((m_pc + 1) & MASK);
         if (m_q.size() > DEPTH) begin
            void'(m_q.pop_front());
            m_err = 1'b1;
         end
         m_pc = tgt & MASK;
      end else if (c || j) begin
         m_pc = tgt & MASK;
      end else if (br) begin
         m_pc = (m_pc + off) & MASK;
      end else begin
         m_pc = (m_pc + 1) & MASK;
      end
   endtask

   task automatic step(input bit r, input bit s, input bit br, input int off,
                       input bit j, input bit c, input bit rt, input int tgt);
      @(negedge clk);
      rst        = r;
      stall      = s;
      branch_en  = br;
      branch_off = AW'(off);
      jump_en    = j;
      call_en    = c;
      ret_en     = rt;
      target     = AW'(tgt);
      #1;
      model(r, s, br, off, j, c, rt, tgt);
      chk("pc_next", 32'(pc_next), 32'(m_pc));
      @(posedge clk);
      #1;
      chk("pc_out", 32'(pc_out), 32'(m_pc));
      chk("ras_empty", 32'(ras_empty), RAS_ON ? 32'(m_q.size() == 0) : 32'd1);
      chk("ras_full", 32'(ras_full), RAS_ON ? 32'(m_q.size() == DEPTH) : 32'd0);
      chk("ras_err", 32'(ras_err), RAS_ON ? 32'(m_err) : 32'd0);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic jmp(input int t);
      step(0, 0, 0, 0, 1, 0, 0, t);
   endtask

   task automatic call(input int t);
      step(0, 0, 0, 0, 0, 1, 0, t);
   endtask

   task automatic ret();
      step(0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      // reset then increment
      step(1, 0, 0, 0, 1, 1, 1, 33);
      chk("reset_pc", 32'(pc_out), 32'd5);
      chk("reset_empty", 32'(ras_empty), 32'd1);
      chk("reset_err", 32'(ras_err), 32'd0);
      repeat (4) idle();
      chk("inc_to_9", 32'(pc_out), 32'd9);

      // increment wraps from all-ones
      jmp(62);
      idle();
      idle();
      chk("inc_wrap", 32'(pc_out), 32'd0);

      // branch wraps both ways
      jmp(3);
      step(0, 0, 1, 6'b111011, 0, 0, 0, 0);
      chk("br_back_wrap", 32'(pc_out), 32'd62);
      step(0, 0, 1, 4, 0, 0, 0, 0);
      chk("br_fwd_wrap", 32'(pc_out), 32'd2);

      // priority and stall
      jmp(10);
      step(0, 0, 1, 7, 1, 0, 0, 20);
      chk("jump_over_br", 32'(pc_out), 32'd20);
      repeat (3) step(0, 1, 0, 0, 1, 0, 0, 30);
      chk("stall_hold", 32'(pc_out), 32'd20);
      jmp(30);
      chk("stall_release", 32'(pc_out), 32'd30);

      // nested call/return
      step(1, 0, 0, 0, 0, 0, 0, 0);
      jmp(1);
      call(10);
      idle();
      call(20);
      idle();
      call(30);
      ret();
      ret();
      ret();
      if (RAS_ON) chk("nest_ret_pc", 32'(pc_out), 32'd2);

      // back-to-back call then return
      jmp(40);
      call(50);
      ret();
      if (RAS_ON) chk("call_ret_b2b", 32'(pc_out), 32'd41);

      // overflow then underflow
      step(1, 0, 0, 0, 0, 0, 0, 0);
      jmp(0);
      for (int i = 1; i <= 5; i++) call(i);
      if (RAS_ON) chk("ovf_full", 32'(ras_full), 32'd1);
      if (RAS_ON) chk("ovf_err", 32'(ras_err), 32'd1);
      repeat (4) ret();
      if (RAS_ON) chk("ovf_last_ret", 32'(pc_out), 32'd2);
      ret();
      ret_en = 1'b0;
      idle();
      step(0, 1, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("err_cleared", 32'(ras_err), 32'd0);

      // call as jump / ret ignored when the stack is absent
      call(40);
      chk("call_target", 32'(pc_out), 32'd40);
      ret();
      if (!RAS_ON) chk("ret_ignored", 32'(pc_out), 32'd41);

      // reset in the middle of a stall
      step(0, 1, 0, 0, 1, 0, 0, 9);
      step(1, 1, 0, 0, 1, 1, 0, 9);
      chk("rst_in_stall", 32'(pc_out), 32'd5);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 39) == 0,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 1) == 1,
              int'($urandom_range(0, MASK)),
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0,
              int'($urandom_range(0, MASK)));
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program counter for the RISC core's fetch stage, replacing the fixed 6-bit load-only counter. It holds the fetch address and each cycle selects increment, PC-relative branch, absolute jump, call or return. A stall holds the counter, and an optional return-address stack supports call/return. The block sits between the control unit (redirect requests) and instruction memory (`pc_out` addresses it directly).

## Interface

Parameters:
- `ADDR_W`, 6: PC width in bits; instruction memory depth is 2^ADDR_W words.
- `RESET_VEC`, 0: value loaded into `pc_out` on reset.
- `RAS_DEPTH`, 4: return-address stack entries; must be a power of two, at least 2.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `stall`, input, 1: hold PC and stack unchanged this cycle.
- `branch_en`, input, 1: PC-relative branch request.
- `branch_off`, input, ADDR_W: signed two's-complement offset, relative to the current `pc_out`.
- `jump_en`, input, 1: absolute jump request.
- `call_en`, input, 1: call request; pushes the return address and jumps.
- `ret_en`, input, 1: return request; pops the stack into the PC.
- `target`, input, ADDR_W: absolute destination for jump and call.
- `pc_out`, output, ADDR_W: registered current fetch address.
- `pc_next`, output, ADDR_W: combinational value `pc_out` will take at the next edge.
- `ras_empty`, output, 1: stack holds no entries.
- `ras_full`, output, 1: stack holds RAS_DEPTH entries.
- `ras_err`, output, 1: sticky error flag; set by a push while full or a pop while empty; cleared only by `rst`.

## Operation

Next-PC selection uses the first true condition, highest priority first:
1. `rst`: `pc_out`, stack pointer and count go to `RESET_VEC`, 0 and 0; `ras_err` clears. Stack contents are don't-care.
2. `stall`: everything holds; `pc_next = pc_out`.
3. `ret_en`:
   - If the stack is not empty: pop; `pc_next` = top entry.
   - If the stack is empty: `pc_next = pc_out + 1`, set `ras_err`.
4. `call_en`:
   - Push `pc_out + 1`; `pc_next = target`.
   - If the stack is full: the push overwrites the oldest entry (circular), the count stays at RAS_DEPTH, and `ras_err` is set.
5. `jump_en`: `pc_next = target`.
6. `branch_en`: `pc_next = pc_out + branch_off`.
7. Otherwise: `pc_next = pc_out + 1`.

Arithmetic:
- All additions are modulo 2^ADDR_W.
- Increment from all-ones wraps to 0, with no flag.
- Branch results wrap silently in both directions.
- Lower-priority requests asserted in the same cycle are ignored, not queued.

Stack:
- LIFO, with a top pointer of log2(RAS_DEPTH) bits and a count of log2(RAS_DEPTH)+1 bits.
- `ras_empty` = (count == 0); `ras_full` = (count == RAS_DEPTH). Both are derived from registered state.

## Timing

- `pc_out` updates one cycle after the request: a request sampled at edge N gives the new `pc_out` after edge N.
- A redirect has zero bubbles inside this block; discarding the wrong-path instruction is the control unit's job.
- `pc_next` is combinational from the inputs and current state, so it is valid within the same cycle for next-address prefetch.
- The first cycle after reset deasserts: `pc_out = RESET_VEC`, `ras_empty = 1`, `ras_full = 0`, `ras_err = 0`.
- Reset mid-operation, including mid-stall, takes effect at the next edge regardless of the other inputs. Any pending redirect is lost.
- A call followed immediately by a return (back-to-back cycles) returns to call-PC + 1. No forwarding hazard exists because the push is registered before the pop is sampled.
- A stall overrides all requests. A request held across a stall is acted on in the first non-stall cycle.

## Configuration

- `PC_RAS_EN` defined:
  - The return-address stack is built as described.
- `PC_RAS_EN` undefined:
  - No stack storage is instantiated.
  - `call_en` behaves exactly as `jump_en`; `ret_en` is ignored and falls through to the lower-priority requests.
  - `ras_empty` is tied to 1; `ras_full` and `ras_err` are tied to 0.
  - The `RAS_DEPTH` parameter is unused.

## Test plan

- Reset and increment: `RESET_VEC=5`, assert `rst` for 1 cycle, then idle 4 cycles -> `pc_out` reads 5, 6, 7, 8, 9. With ADDR_W=6, start from 62 -> 62, 63, 0.
- Branch wrap: `pc_out=3`, `branch_en`, `branch_off=6'b111011` (-5) -> `pc_out=62` next cycle. Then `branch_off=4` -> `pc_out=2`.
- Priority and stall: `pc_out=10`, `jump_en` with `target=20` plus `branch_en` -> `pc_out=20`. Then `stall` with `jump_en`, `target=30` held 3 cycles -> `pc_out` stays 20. Release stall -> `pc_out=30`.
- Nested call/return, RAS_DEPTH=4: calls from PCs 1, 11 and 21 to targets 10, 20, 30, then three returns -> `pc_out` sequence 10, 20, 30, 22, 12, 2. Also check `ras_empty` at the end.
- Overflow and underflow: 5 consecutive calls -> `ras_full=1` and `ras_err=1`; 4 returns yield return addresses 5 down to 2, and the oldest entry is lost. A further return on an empty stack -> `pc_out` increments and `ras_err` stays 1 until `rst`.
- Macro off: build without `PC_RAS_EN`; `call_en` with `target=40` -> `pc_out=40`; `ret_en` alone -> `pc_out=41`; `ras_empty=1` throughout.
